systolic_drain_collector: RTL and testbench



---
 rtl/drain_collector_pkg.sv | 25 ++
 rtl/drain_col_slice.sv | 68 ++++++
 rtl/systolic_drain_collector.sv | 174 +++++++++++++++++
 tb/tb_systolic_drain_collector.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/drain_collector_pkg.sv
// Shared sizes and state encodings for the systolic drain collector.
package drain_collector_pkg;

  localparam int D_W   = 8;
  localparam int N     = 4;
  localparam int M     = 4;
  localparam int RES_W = 2 * D_W;
  localparam int DEPTH = N * M;
  localparam int ROW_W = $clog2(N);
  localparam int COL_W = $clog2(M);
  // Per-column word counter must be able to hold N itself.
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } bank_state_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } rd_state_t;

endpackage

// File: rtl/drain_col_slice.sv
// One column of the collector: two banks of N result words, the drain word
// counter for the tile being filled, and a sticky protocol error flag.
module drain_col_slice
  import drain_collector_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  input  logic [RES_W-1:0] i_data,
  input  logic             i_wr_bank,
  input  logic             i_wr_full,
  input  logic             i_close,
  input  logic             i_rd_bank,
  input  logic [ROW_W-1:0] i_rd_row,
  output logic [RES_W-1:0] o_rd_data,
  output logic             o_done_next,
  output logic             o_proto_err
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_proto_err;
  logic [RES_W-1:0] r_mem [2][N];

  logic             w_at_n;
  logic             w_accept;
  logic [ROW_W-1:0] w_wr_row;

  assign w_at_n   = (r_cnt == CNT_W'(N));
  assign w_accept = i_valid && !i_wr_full && !w_at_n;
  // The array drains bottom row first, so the first word lands in row N-1.
  assign w_wr_row = ROW_W'(N - 1) - r_cnt[ROW_W-1:0];

  // This column has (or is completing this cycle) its full set of N words.
  assign o_done_next = w_at_n || (w_accept && (r_cnt == CNT_W'(N - 1)));

  // Count accepted drain words; a tile close restarts every column at zero.
  always_ff @(posedge clk) begin
    // NOTE: registered state is always updated with <= so every flop samples pre-edge values.
    if (rst) begin
      r_cnt <= '0;
    end else if (i_close) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Latch a protocol error when the column over-sends inside one tile.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (i_valid && w_at_n) begin
      r_proto_err <= 1'b1;
    end
  end

  // Result storage; bank validity is tracked at the top, so contents need no reset.
  always_ff @(posedge clk) begin
    // NOTE: storage arrays are deliberately not reset; the bank state decides what is valid.
    if (w_accept) begin
      r_mem[i_wr_bank][w_wr_row] <= i_data;
    end
  end

  assign o_rd_data   = r_mem[i_rd_bank][i_rd_row];
  assign o_proto_err = r_proto_err;

endmodule

// File: rtl/systolic_drain_collector.sv
// Collects per-column drain words from the systolic array into double-buffered
// tiles and streams each complete tile out row-major with backpressure.
module systolic_drain_collector
  import drain_collector_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [M*RES_W-1:0] col_data,
  input  logic [M-1:0]       col_valid,
  output logic [RES_W-1:0]   m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic               m_last,
  output logic [ROW_W-1:0]   m_row,
  output logic [COL_W-1:0]   m_col,
  output logic               overflow,
  output logic               proto_err
);

  bank_state_t      r_bank_state [2];
  logic             r_wr_bank;
  logic             r_rd_bank;
  rd_state_t        r_rd_state;
  logic [RES_W-1:0] r_m_data;
  logic             r_m_valid;
  logic             r_m_last;
  logic [ROW_W-1:0] r_m_row;
  logic [COL_W-1:0] r_m_col;
  logic             r_overflow;

  logic             w_wr_full;
  logic             w_close;
  logic             w_accept_out;
  logic             w_free;
  logic             w_rd_full;
  logic [M-1:0]     w_done_next;
  logic [M-1:0]     w_col_proto;
  logic [RES_W-1:0] w_slice_data [M];
  logic [ROW_W-1:0] w_rd_row;
  logic [COL_W-1:0] w_rd_col;
  logic             w_rd_last;
  logic [RES_W-1:0] w_rd_word;

  assign w_wr_full    = (r_bank_state[r_wr_bank] == FULL);
  assign w_close      = &w_done_next;
  assign w_accept_out = r_m_valid && m_ready;
  assign w_free       = w_accept_out && r_m_last;
  // Look through a close into the read bank so the first word is not delayed a cycle.
  assign w_rd_full    = (r_bank_state[r_rd_bank] == FULL) ||
                        (w_close && (r_wr_bank == r_rd_bank));

  for (genvar g = 0; g < M; g++) begin : g_col
    drain_col_slice u_slice (
      .clk         (clk),
      .rst         (rst),
      .i_valid     (col_valid[g]),
      .i_data      (col_data[g*RES_W +: RES_W]),
      .i_wr_bank   (r_wr_bank),
      .i_wr_full   (w_wr_full),
      .i_close     (w_close),
      .i_rd_bank   (r_rd_bank),
      .i_rd_row    (w_rd_row),
      .o_rd_data   (w_slice_data[g]),
      .o_done_next (w_done_next[g]),
      .o_proto_err (w_col_proto[g])
    );
  end

  // Address of the word to load next: (0,0) outside STREAM, else the row-major successor.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latch).
    w_rd_row = '0;
    w_rd_col = '0;
    if (r_rd_state == STREAM) begin
      if (r_m_col == COL_W'(M - 1)) begin
        w_rd_row = r_m_row + 1'b1;
        w_rd_col = '0;
      end else begin
        w_rd_row = r_m_row;
        w_rd_col = r_m_col + 1'b1;
      end
    end
  end

  assign w_rd_word = w_slice_data[w_rd_col];
  assign w_rd_last = (w_rd_row == ROW_W'(N - 1)) && (w_rd_col == COL_W'(M - 1));

  // Bank status: a close marks the write bank FULL, accepting the last word frees the read bank.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank_state[0] <= EMPTY;
      r_bank_state[1] <= EMPTY;
    end else begin
      if (w_close) begin
        r_bank_state[r_wr_bank] <= FULL;
      end
      if (w_free) begin
        r_bank_state[r_rd_bank] <= EMPTY;
      end
    end
  end

  // Write bank pointer flips on every tile close.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank <= 1'b0;
    end else if (w_close) begin
      r_wr_bank <= ~r_wr_bank;
    end
  end

  // Sticky overflow: any drain word aimed at a bank that is still FULL.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if ((|col_valid) && w_wr_full) begin
      r_overflow <= 1'b1;
    end
  end

  // Read FSM: wait for a full bank, present (0,0), then advance one word per accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rd_state <= IDLE;
      r_rd_bank  <= 1'b0;
      r_m_data   <= '0;
      r_m_valid  <= 1'b0;
      r_m_last   <= 1'b0;
      r_m_row    <= '0;
      r_m_col    <= '0;
    end else begin
      case (r_rd_state)
        IDLE: begin
          if (w_rd_full) begin
            r_rd_state <= LOAD;
          end
        end
        LOAD: begin
          r_m_data   <= w_rd_word;
          r_m_row    <= w_rd_row;
          r_m_col    <= w_rd_col;
          r_m_last   <= w_rd_last;
          r_m_valid  <= 1'b1;
          r_rd_state <= STREAM;
        end
        STREAM: begin
          if (w_accept_out) begin
            if (r_m_last) begin
              r_m_valid  <= 1'b0;
              r_m_last   <= 1'b0;
              r_rd_bank  <= ~r_rd_bank;
              r_rd_state <= IDLE;
            end else begin
              r_m_data <= w_rd_word;
              r_m_row  <= w_rd_row;
              r_m_col  <= w_rd_col;
              r_m_last <= w_rd_last;
            end
          end
        end
        default: r_rd_state <= IDLE;
      endcase
    end
  end

  assign m_data    = r_m_data;
  assign m_valid   = r_m_valid;
  assign m_last    = r_m_last;
  assign m_row     = r_m_row;
  assign m_col     = r_m_col;
  assign overflow  = r_overflow;
  assign proto_err = |w_col_proto;

endmodule

// File: tb/tb_systolic_drain_collector.sv
// Directed bench for systolic_drain_collector: aligned and skewed tiles,
// backpressure, double buffering with overflow, protocol error, mid-stream reset.
module tb_systolic_drain_collector;
  import drain_collector_pkg::*;

  logic               clk;
  logic               rst;
  logic [M*RES_W-1:0] col_data;
  logic [M-1:0]       col_valid;
  logic [RES_W-1:0]   m_data;
  logic               m_valid;
  logic               m_ready;
  logic               m_last;
  logic [ROW_W-1:0]   m_row;
  logic [COL_W-1:0]   m_col;
  logic               overflow;
  logic               proto_err;

  int n_assert = 0;
  int n_fail   = 0;
  int span;
  int sent   [M];
  int next_t [M];
  int total;
  int k;

  systolic_drain_collector dut (
    .clk       (clk),
    .rst       (rst),
    .col_data  (col_data),
    .col_valid (col_valid),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .m_row     (m_row),
    .m_col     (m_col),
    .overflow  (overflow),
    .proto_err (proto_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of test, required end within 500000 time units");
    $fatal(1, "simulation timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Every column delivers rows N-1..0 of a tile on N consecutive cycles.
  task automatic drive_tile(input int base);
    for (int r = N - 1; r >= 0; r--) begin
      col_valid = '1;
      for (int c = 0; c < M; c++) begin
        col_data[c*RES_W +: RES_W] = RES_W'(base + 100 * r + c);
      end
      @(negedge clk);
    end
    col_valid = '0;
  endtask

  // Accept nwords words and compare each presented word against the row-major model.
  task automatic collect(input string tag, input int base, input bit alt,
                         input int nwords, output int span_o);
    int idx      = 0;
    int cyc      = 0;
    int first    = -1;
    int last_acc = 0;
    bit rdy;
    while (idx < nwords && cyc < 400) begin
      rdy     = alt ? (cyc % 2 == 0) : 1'b1;
      m_ready = rdy;
      if (m_valid) begin
        if (first < 0) first = cyc;
        check({tag, "_data"}, 32'(m_data), 32'(base + 100 * (idx / M) + (idx % M)));
        check({tag, "_row"},  32'(m_row),  32'(idx / M));
        check({tag, "_col"},  32'(m_col),  32'(idx % M));
        check({tag, "_last"}, 32'(m_last), 32'(idx == N * M - 1));
        if (rdy) begin
          idx++;
          last_acc = cyc;
        end
      end
      @(negedge clk);
      cyc++;
    end
    m_ready = 1'b0;
    check({tag, "_count"}, 32'(idx), 32'(nwords));
    span_o = (first < 0) ? 0 : (last_acc - first + 1);
  endtask

  initial begin
    rst       = 1'b1;
    m_ready   = 1'b0;
    col_valid = '0;
    col_data  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    check("rst_m_valid",   32'(m_valid),   32'd0);
    check("rst_m_last",    32'(m_last),    32'd0);
    check("rst_m_data",    32'(m_data),    32'd0);
    check("rst_m_row",     32'(m_row),     32'd0);
    check("rst_m_col",     32'(m_col),     32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_proto_err", 32'(proto_err), 32'd0);

    // 1: aligned tile, two-cycle latency from final drain word to m_valid
    drive_tile(0);
    check("t1_lat_t1", 32'(m_valid), 32'd0);
    @(negedge clk);
    check("t1_lat_t2", 32'(m_valid), 32'd1);
    collect("t1", 0, 1'b0, 16, span);

    // 2: skewed columns with random gaps; nothing streams before the tile closes
    total = 0;
    for (int c = 0; c < M; c++) begin
      sent[c]   = 0;
      next_t[c] = c;
    end
    k = 0;
    while (k < 80 && total < N * M) begin
      check("t2_no_early_valid", 32'(m_valid), 32'd0);
      col_valid = '0;
      for (int c = 0; c < M; c++) begin
        if (sent[c] < N && k >= next_t[c]) begin
          col_valid[c] = 1'b1;
          col_data[c*RES_W +: RES_W] = RES_W'(100 * (N - 1 - sent[c]) + c);
          sent[c]++;
          total++;
          next_t[c] = k + 1 + int'($urandom_range(0, 3));
        end
      end
      @(negedge clk);
      k++;
    end
    col_valid = '0;
    check("t2_sent", 32'(total), 32'(N * M));
    collect("t2", 0, 1'b0, 16, span);

    // 3: alternating backpressure, words hold while stalled
    drive_tile(0);
    collect("t3", 0, 1'b1, 16, span);
    check("t3_span_le32", 32'(span <= 32), 32'd1);
    check("t3_span_ge31", 32'(span >= 31), 32'd1);

    // 4: second tile buffered under full backpressure, then overflow on a third tile
    drive_tile(0);
    drive_tile(1000);
    check("t4_overflow_pre", 32'(overflow), 32'd0);
    col_valid[0] = 1'b1;
    col_data[0 +: RES_W] = RES_W'(9999);
    @(negedge clk);
    col_valid = '0;
    check("t4_overflow_set", 32'(overflow), 32'd1);
    collect("t4a", 0, 1'b0, 16, span);
    collect("t4b", 1000, 1'b0, 16, span);

    // 5: column 0 sends a fifth word before the others finish
    for (int kk = 0; kk < 6; kk++) begin
      if (kk == 4) check("t5_proto_pre", 32'(proto_err), 32'd0);
      col_valid = '0;
      if (kk < 4) begin
        col_valid[0] = 1'b1;
        col_data[0 +: RES_W] = RES_W'(100 * (3 - kk));
      end else if (kk == 4) begin
        col_valid[0] = 1'b1;
        col_data[0 +: RES_W] = RES_W'(7777);
      end
      if (kk >= 2) begin
        for (int c = 1; c < M; c++) begin
          col_valid[c] = 1'b1;
          col_data[c*RES_W +: RES_W] = RES_W'(100 * (5 - kk) + c);
        end
      end
      @(negedge clk);
    end
    col_valid = '0;
    check("t5_proto_set", 32'(proto_err), 32'd1);
    collect("t5", 0, 1'b0, 16, span);

    // 6: reset after seven accepted words, then a fresh tile
    drive_tile(0);
    collect("t6a", 0, 1'b0, 7, span);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6_rst_m_valid",   32'(m_valid),   32'd0);
    check("t6_rst_m_last",    32'(m_last),    32'd0);
    check("t6_rst_m_row",     32'(m_row),     32'd0);
    check("t6_rst_m_col",     32'(m_col),     32'd0);
    check("t6_rst_overflow",  32'(overflow),  32'd0);
    check("t6_rst_proto_err", 32'(proto_err), 32'd0);
    @(negedge clk);
    check("t6_idle_after_rst", 32'(m_valid), 32'd0);
    drive_tile(2000);
    collect("t6b", 2000, 1'b0, 16, span);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
